uart_rx_frame: RTL and testbench

Parametrised successor to the fixed 4+4-bit serial command receiver. Oversampled UART receiver with configurable baud, word width and instruction/data split. Validates start and stop bits and buffers decoded words in a small FIFO with a valid/ready output handshake. Sits between the serial input pin and the command handler, which drives the LEDs and 7-segment display.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/rx_fifo.sv | 60 ++++++
 rtl/uart_rx_frame.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampled UART frame receiver.
// FSM state encodings, tick divider helper and synchroniser depth.
package uart_rx_pkg;

   localparam int SYNC_STAGES = 2;

   typedef logic [2:0] rx_state_t;

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_PARITY = 3'd3;
   localparam rx_state_t ST_STOP   = 3'd4;
   localparam rx_state_t ST_BREAK  = 3'd5;

   function automatic int tick_div(input int clk_hz, input int baud, input int os);
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO with a combinational head read.
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_cnt == (AW+1)'(DEPTH));
   assign empty     = (r_cnt == '0);
   assign count     = r_cnt;
   assign rdata     = r_mem[r_rd];
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver feeding a word FIFO with valid/ready output.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop.
module uart_rx_frame
   import uart_rx_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int INSTR_BITS = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [INSTR_BITS-1:0]           instrucao,
   output logic [DATA_BITS-INSTR_BITS-1:0] dado,
   output logic                            frame_err,
   output logic                            parity_err,
   output logic                            overrun,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW       = $clog2(OVERSAMPLE);
   localparam int BW       = $clog2(DATA_BITS + 1);

   if (TICK_DIV < 1) begin : g_bad_div
      $error("uart_rx_frame: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 1");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic [DW-1:0]          r_div;
   rx_state_t              r_state;
   logic [SW-1:0]          r_scnt;
   logic [BW-1:0]          r_bcnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_ferr;
   logic                   r_ovr;

   logic                   w_rxs;
   logic                   w_tick;
   logic                   w_half;
   logic                   w_mid;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_par_bad;
   logic [DATA_BITS-1:0]   w_head;

   assign w_rxs  = r_sync[SYNC_STAGES-1];
   assign w_tick = (r_div == DW'(TICK_DIV - 1));
   assign w_half = (r_scnt == SW'(OVERSAMPLE/2 - 1));
   assign w_mid  = (r_scnt == SW'(OVERSAMPLE - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync <= '1;
         r_div  <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in};
         r_div  <= w_tick ? '0 : r_div + 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t ST_AFTER_DATA = ST_PARITY;

   logic r_perr;
   logic r_par_bad;
   logic w_par_sample;
   logic w_par_miss;

   assign w_par_sample = (r_state == ST_PARITY) && w_tick && w_mid;
   assign w_par_miss   = w_rxs != (^r_shift ^ PARITY_ODD[0]);
   assign w_par_bad    = r_par_bad;
   assign parity_err   = r_perr;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_perr    <= 1'b0;
         r_par_bad <= 1'b0;
      end else begin
         r_perr <= w_par_sample && w_par_miss;
         if (r_state == ST_IDLE) begin
            r_par_bad <= 1'b0;
         end else if (w_par_sample && w_par_miss) begin
            r_par_bad <= 1'b1;
         end
      end
   end
`else
   localparam rx_state_t ST_AFTER_DATA = ST_STOP;

   logic w_unused_par;

   assign w_unused_par = PARITY_ODD[0];
   assign w_par_bad    = 1'b0;
   assign parity_err   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_scnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_ferr  <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (!w_rxs) begin
                  r_scnt  <= '0;
                  r_bcnt  <= '0;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (w_half) begin
                     r_scnt  <= '0;
                     r_state <= w_rxs ? ST_IDLE : ST_DATA;
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (w_mid) begin
                     r_scnt  <= '0;
                     r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                     r_bcnt  <= r_bcnt + 1'b1;
                     if (r_bcnt == BW'(DATA_BITS - 1)) begin
                        r_state <= ST_AFTER_DATA;
                     end
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  if (w_mid) begin
                     r_scnt  <= '0;
                     r_state <= ST_STOP;
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (w_tick) begin
                  if (w_mid) begin
                     r_scnt <= '0;
                     if (w_rxs) begin
                        r_state <= ST_IDLE;
                     end else begin
                        // a parity failure already reported this frame
                        r_ferr  <= !w_par_bad;
                        r_state <= ST_BREAK;
                     end
                  end else begin
                     r_scnt <= r_scnt + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (w_rxs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_push = (r_state == ST_STOP) && w_tick && w_mid && w_rxs && !w_par_bad;
   assign w_pop  = !w_empty && out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ovr <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_ovr <= 1'b1;
      end
   end

   rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst   (reset),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (r_shift),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

   assign out_valid = !w_empty;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;
   assign {instrucao, dado} = w_empty ? '0 : w_head;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a word scoreboard.
// Runs with TICK_DIV=1, OVERSAMPLE=16, 8 data bits, 4-deep FIFO.
module tb_uart_rx_frame;

   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME    = OS * NBITS;
   localparam int STOP_CYC = FRAME - 5;

   logic       clock = 1'b0;
   logic       reset;
   logic       in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] instrucao;
   logic [3:0] dado;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic [2:0] fifo_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ferr = 0;
   int n_perr = 0;
   int exp_perr = 0;
   int f0;
   logic [7:0] sb [$];

   uart_rx_frame #(
      .CLK_HZ     (16),
      .BAUD       (1),
      .OVERSAMPLE (OS),
      .DATA_BITS  (8),
      .INSTR_BITS (4),
      .FIFO_DEPTH (4),
      .PARITY_ODD (0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in         (in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .instrucao  (instrucao),
      .dado       (dado),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .fifo_count (fifo_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic even_par(input logic [7:0] d);
      return ^d;
   endfunction

   always @(negedge clock) begin
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (frame_err && parity_err) begin
         n_cmp++;
         n_bad++;
         $error("FAIL both_err: frame_err and parity_err high together");
      end
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL extra_word: observed 0x%0h expected none", {instrucao, dado});
         end else begin
            chk("sb_word", int'({instrucao, dado}), int'(sb.pop_front()));
         end
      end
   end

   // rdy_cyc: cycle at which out_ready is pulsed; rst_cyc: cycle to reset
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                             input int rdy_cyc, input int rst_cyc);
      for (int c = 0; c < FRAME; c++) begin
         int idx;
         idx = c / OS;
         @(posedge clock);
         #1;
         if (rst_cyc >= 0 && c == rst_cyc + 1) begin
            reset = 1'b0;
            in    = 1'b1;
            return;
         end
         reset = (c == rst_cyc);
         if (rdy_cyc >= 0) out_ready = (c == rdy_cyc);
         if (idx == 0) in = 1'b0;
         else if (idx <= 8) in = d[idx-1];
         else if (idx == NBITS - 1) in = stop;
         else in = par;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drain(input int n);
      @(posedge clock);
      #1 out_ready = 1'b1;
      repeat (n) @(posedge clock);
      #1 out_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_instr", instrucao, 0);
      chk("rst_dado", dado, 0);
      reset = 1'b0;
      idle(5);

      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, even_par(8'hA5), -1, -1);
      chk("a5_valid", out_valid, 1);
      chk("a5_instr", instrucao, 4'hA);
      chk("a5_dado", dado, 4'h5);
      chk("a5_count", fifo_count, 1);
      out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      chk("a5_pop_valid", out_valid, 0);
      chk("a5_pop_count", fifo_count, 0);
      chk("a5_sb_empty", sb.size(), 0);

      f0 = n_ferr;
      @(posedge clock);
      #1 in = 1'b0;
      repeat (3) @(posedge clock);
      #1 in = 1'b1;
      idle(40);
      chk("glitch_count", fifo_count, 0);
      chk("glitch_valid", out_valid, 0);
      chk("glitch_ferr", n_ferr - f0, 0);

      f0 = n_ferr;
      send_frame(8'h3C, 1'b0, even_par(8'h3C), -1, -1);
      repeat (40) @(posedge clock);
      #1 in = 1'b1;
      idle(20);
      chk("ferr_pulses", n_ferr - f0, 1);
      chk("ferr_count", fifo_count, 0);
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1, even_par(8'h11), -1, -1);
      chk("after_ferr_count", fifo_count, 1);
      drain(3);
      chk("after_ferr_sb", sb.size(), 0);

      for (int v = 1; v <= 5; v++) begin
         if (v <= 4) sb.push_back(8'(v));
         send_frame(8'(v), 1'b1, even_par(8'(v)), -1, -1);
      end
      idle(3);
      chk("full_count", fifo_count, 4);
      chk("full_ovr", overrun, 1);
      drain(8);
      chk("full_sb", sb.size(), 0);
      chk("full_drained", fifo_count, 0);
      chk("ovr_sticky", overrun, 1);
      pulse_reset();
      chk("ovr_reset", overrun, 0);

      for (int v = 1; v <= 4; v++) begin
         sb.push_back(8'(v + 8'h20));
         send_frame(8'(v + 8'h20), 1'b1, even_par(8'(v + 8'h20)), -1, -1);
      end
      sb.push_back(8'h25);
      send_frame(8'h25, 1'b1, even_par(8'h25), STOP_CYC - 1, -1);
      idle(3);
      chk("swap_count", fifo_count, 4);
      chk("swap_ovr", overrun, 0);
      drain(8);
      chk("swap_sb", sb.size(), 0);
      chk("swap_ovr_end", overrun, 0);

`ifdef UART_RX_PARITY_EN
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1, -1, -1);
      chk("par_ok_count", fifo_count, 1);
      drain(3);
      f0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0, -1, -1);
      idle(3);
      exp_perr = 1;
      chk("par_bad_pulse", n_perr - f0, 1);
      chk("par_bad_count", fifo_count, 0);
`endif

      sb.push_back(8'h77);
      send_frame(8'h77, 1'b1, even_par(8'h77), -1, -1);
      chk("pre_rst_count", fifo_count, 1);
      send_frame(8'h55, 1'b1, even_par(8'h55), -1, 60);
      sb.delete();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_instr", instrucao, 0);
      chk("mid_rst_dado", dado, 0);
      chk("mid_rst_ferr", frame_err, 0);
      idle(20);
      sb.push_back(8'h66);
      send_frame(8'h66, 1'b1, even_par(8'h66), -1, -1);
      chk("post_rst_count", fifo_count, 1);
      chk("post_rst_instr", instrucao, 4'h6);
      chk("post_rst_dado", dado, 4'h6);
      drain(3);
      chk("post_rst_sb", sb.size(), 0);
      chk("perr_total", n_perr, exp_perr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
